seg_msg_sequencer: RTL
======================

# seg_msg_sequencer

Playback controller for the board's single seven-segment digit. It buffers a short message of 6-bit character codes (the display code set: 0–15 hex digits, 16–41 letters and the degree sign) and plays it one character at a time at a fixed dwell. Between characters it inserts a blank cycle so that repeated characters remain distinguishable. Its `char_code`/`char_valid` outputs feed the existing seven-segment decoder, and its write/start controls are driven from `SWI`.

## Interface
- `DEPTH`, 8: message buffer entries (≥2).
- `CODE_BITS`, 6: character code width.
- `DWELL`, 4: `clk_2` cycles each character is shown (≥1).
- `clk_2` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: append `wr_code` to the buffer when `wr_ready` is also high.
- `wr_code` in `CODE_BITS`: character code to append.
- `wr_ready` out 1: combinational; high iff state is IDLE and `count < DEPTH`.
- `start` in 1: begin playback; acted on only in IDLE with a non-empty buffer.
- `loop` in 1: sampled together with an accepted `start`; 1 = repeat the message forever.
- `stop` in 1: abort playback and return to IDLE; the buffer is kept.
- `clear` in 1: empty the buffer; acted on only in IDLE.
- `char_code` out `CODE_BITS`: current character code (registered).
- `char_valid` out 1: 1 = display `char_code`; 0 = blank the digit.
- `busy` out 1: high in SHOW or GAP.
- `done` out 1: one-cycle pulse when a non-loop playback completes.
- `count` out `$clog2(DEPTH+1)`: number of stored characters.

## Operation
- **States:** IDLE, SHOW, GAP. Registers: `buf[DEPTH]`, `count`, `idx`, `dwell_cnt`, `loop_q`.
- **IDLE:**
  - A write handshake stores `wr_code` in `buf[count]`, then `count` increments.
  - `clear` sets `count` to 0.
  - `start` with the effective `count > 0` sets `idx` to 0, `dwell_cnt` to 0 and `loop_q` to `loop`, then moves to SHOW.
  - `start` with `count == 0` is ignored, and no `done` is generated.
- **SHOW:**
  - Outputs `char_code = buf[idx]` and `char_valid = 1`.
  - `dwell_cnt` increments each cycle. At `DWELL-1` the block moves to GAP.
- **GAP (exactly one cycle):**
  - Outputs `char_valid = 0`; `char_code` holds its last value.
  - If `idx < count-1`: increment `idx` and go to SHOW.
  - Else if `loop_q`: set `idx` to 0 and go to SHOW.
  - Else: pulse `done` and go to IDLE.
- **stop:** from SHOW or GAP, go to IDLE next cycle with `char_valid = 0`. No `done` is generated.
- **Priorities in the same cycle:**
  - `stop` beats the end-of-message transition.
  - `clear` beats `wr_valid`; the write is dropped and `wr_ready` is ignored.
  - `clear` with `start`: `clear` wins and the start is ignored.
  - `wr_valid` with `start` in IDLE: both take effect, and the message length includes the new character.
  - `wr_valid` when full or when not in IDLE: no effect.
- **Unsupported codes:** codes 42–63 are stored and played unchanged; the decoder shows them as "-".
- **Reset values:** state IDLE, `count = 0`, `idx = 0`, `dwell_cnt = 0`, `loop_q = 0`, `char_code = 0`, `char_valid = 0`, `busy = 0`, `done = 0`. Buffer contents are don't-care.
- **Reset mid-playback:** the block enters IDLE immediately, the outputs take their reset values and the message is lost.

## Timing
- **Start latency:** `start` accepted at edge t. At t+1 the state is SHOW, `char_valid = 1`, `char_code = buf[0]` and `busy = 1`.
- **Per character:** each character occupies `DWELL` SHOW cycles plus 1 GAP cycle.
- **Message period:** one message of N characters takes `N·(DWELL+1)` cycles.
- **Completion:** `done` is high for the one cycle after the final GAP. That cycle coincides with the first IDLE cycle, in which `busy = 0`.
- **stop latency:** `stop` at edge t gives IDLE at t+1 with `char_valid = 0`.
- **Counter widths:** `dwell_cnt` is `$clog2(DWELL)` bits (minimum 1). `idx` is `$clog2(DEPTH)` bits.

## Structure
- **Package `seg_seq_pkg`:** `state_t` enum (IDLE, SHOW, GAP), `CODE_BITS`, and named code constants (`CODE_DASH = 6'd63`, `CODE_DEGREE = 6'd41`).
- **Sub-module:** none. The buffer, FSM and dwell counter live in one module.

## Test plan
- **Basic playback:** DEPTH=8, DWELL=4. Write 16, 21, 29 ("A", "E", "L"), then `start` with `loop = 0`. The `char_code`/`char_valid` sequence must be 16×4, blank, 21×4, blank, 29×4, blank. `done` pulses at cycle 16 after start.
- **Loop and stop:** same message with `loop = 1`. After 30 cycles, 16 must reappear at cycles 16 and 31. Assert `stop` in a SHOW cycle; the next cycle has `busy = 0`, `char_valid = 0` and no `done`.
- **Full buffer:** write 9 codes 0..8. The first 8 are accepted, `count = 8`, and `wr_ready = 0` on the 9th. Playback shows 0..7.
- **Empty and clear:** `start` with `count = 0` gives no state change and no `done`. Assert `clear` and `wr_valid` together with `count = 3`; the result is `count = 0` and the write is dropped.
- **Write and start together:** in IDLE with `count = 1`, assert `wr_valid` and `start` in the same cycle. The resulting playback is 2 characters long.
- **Reset mid-playback:** assert `rst_n = 0` during GAP. All outputs immediately take their reset values and `count = 0`.

Source files
------------

// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the seven-segment message sequencer.
// Holds the playback state encoding and the display code set width.
package seg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam int CODE_BITS = 6;

  // Codes the downstream decoder treats specially.
  localparam logic [CODE_BITS-1:0] CODE_DASH   = 6'd63;
  localparam logic [CODE_BITS-1:0] CODE_DEGREE = 6'd41;

endpackage

// File: rtl/seg_msg_sequencer.sv
// Buffers a short message of display codes and plays it on one seven-segment
// digit: DWELL cycles per character, one blank cycle between characters.
module seg_msg_sequencer #(
  parameter int DEPTH     = 8,
  parameter int CODE_BITS = 6,
  parameter int DWELL     = 4
) (
  input  logic                         clk_2,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  input  logic [CODE_BITS-1:0]         wr_code,
  output logic                         wr_ready,
  input  logic                         start,
  input  logic                         loop,
  input  logic                         stop,
  input  logic                         clear,
  output logic [CODE_BITS-1:0]         char_code,
  output logic                         char_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  import seg_seq_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  state_t               state_q;
  logic [CODE_BITS-1:0] mem_q [DEPTH];
  logic [CW-1:0]        count_q;
  logic [IW-1:0]        idx_q;
  logic [DW-1:0]        dwell_q;
  logic                 loop_q;
  logic [CODE_BITS-1:0] char_code_q;
  logic                 char_valid_q;
  logic                 done_q;

  logic                 wr_fire;
  logic [CW-1:0]        count_d;
  logic [IW-1:0]        idx_next;
  logic                 more_chars;
  logic [CODE_BITS-1:0] first_code;

  always_comb begin
    wr_ready   = (state_q == IDLE) && (count_q < DEPTH_C);
    wr_fire    = wr_ready && wr_valid && !clear;
    count_d    = wr_fire ? count_q + CW'(1) : count_q;
    idx_next   = idx_q + IW'(1);
    more_chars = (CW'(idx_q) + CW'(1)) < count_q;
    // A start on an empty buffer only succeeds alongside a write, so the
    // first character is still in flight on wr_code rather than in mem_q.
    first_code = (count_q == '0) ? wr_code : mem_q[0];
  end

  always_ff @(posedge clk_2) begin
    if (wr_fire) begin
      mem_q[count_q[IW-1:0]] <= wr_code;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      dwell_q      <= '0;
      loop_q       <= 1'b0;
      char_code_q  <= '0;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            count_q <= '0;
          end else begin
            count_q <= count_d;
            if (start && (count_d != '0)) begin
              idx_q        <= '0;
              dwell_q      <= '0;
              loop_q       <= loop;
              char_code_q  <= first_code;
              char_valid_q <= 1'b1;
              state_q      <= SHOW;
            end
          end
        end
        SHOW: begin
          if (stop) begin
            char_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else if (dwell_q == DWELL_LAST) begin
            char_valid_q <= 1'b0;
            state_q      <= GAP;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        GAP: begin
          // stop outranks wrapping or finishing the message.
          if (stop) begin
            state_q <= IDLE;
          end else if (more_chars) begin
            idx_q        <= idx_next;
            dwell_q      <= '0;
            char_code_q  <= mem_q[idx_next];
            char_valid_q <= 1'b1;
            state_q      <= SHOW;
          end else if (loop_q) begin
            idx_q        <= '0;
            dwell_q      <= '0;
            char_code_q  <= mem_q[0];
            char_valid_q <= 1'b1;
            state_q      <= SHOW;
          end else begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_code  = char_code_q;
  assign char_valid = char_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign count      = count_q;

endmodule
